// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared definitions for the AXI4-Lite register-file slave.
//   - AXI response codes
//   - write and read channel FSM state encodings
//   - clog2 helper used to derive the byte-lane shift and index widths
package axi4_lite_pkg;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

   typedef enum logic [1:0] {
      WIdle,
      WWaitData,
      WWaitAddr,
      WResp
   } w_state_e;

   typedef enum logic [0:0] {
      RIdle,
      RData
   } r_state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// axi4_lite_addr_decode: combinational address decoder for the register file.
//   addr_i      byte address from the AXI address channel
//   index_o     word index of the addressed register (valid when in_range_o)
//   in_range_o  address falls inside [BASE_ADDR, BASE_ADDR + NUM_REGS words)
//   is_ro_o     addressed register is read-only (only meaningful when in range)
module axi4_lite_addr_decode
   import axi4_lite_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           NUM_REGS   = 16,
   parameter int unsigned           IDX_WIDTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [IDX_WIDTH-1:0]  index_o,
   output logic                  in_range_o,
   output logic                  is_ro_o
);

   localparam int unsigned LaneShift = clog2(DATA_WIDTH / 8);

   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] word_idx;

   always_comb begin
      offset     = addr_i - BASE_ADDR;
      // Sub-word address bits are shifted away and so ignored.
      word_idx   = offset >> LaneShift;
      in_range_o = (addr_i >= BASE_ADDR) && (word_idx < ADDR_WIDTH'(NUM_REGS));
      index_o    = word_idx[IDX_WIDTH-1:0];
      is_ro_o    = in_range_o && RO_MASK[index_o];
   end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// axi4_lite_regfile_slave: AXI4-Lite slave with an internal register file.
//   iCLK/iRST       clock, asynchronous active-low reset
//   s_AW*/s_W*/s_B* write address / data / response channels
//   s_AR*/s_R*      read address / data channels
//   oREGS           flat view of the R/W registers (slice i = register i)
//   iSTATUS         status sources returned on reads of read-only registers
//   oWR_PULSE       one-cycle pulse when a register's new value becomes visible
//   oRD_PULSE       one-cycle pulse when RVALID rises for a register
module axi4_lite_regfile_slave
   import axi4_lite_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
   input  logic                           iCLK,
   input  logic                           iRST,
   input  logic                           s_AWVALID,
   output logic                           s_AWREADY,
   input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
   input  logic [2:0]                     s_AWPROT,
   input  logic                           s_WVALID,
   output logic                           s_WREADY,
   input  logic [DATA_WIDTH-1:0]          s_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        s_WSTRB,
   output logic                           s_BVALID,
   input  logic                           s_BREADY,
   output logic [1:0]                     s_BRESP,
   input  logic                           s_ARVALID,
   output logic                           s_ARREADY,
   input  logic [ADDR_WIDTH-1:0]          s_ARADDR,
   input  logic [2:0]                     s_ARPROT,
   output logic                           s_RVALID,
   input  logic                           s_RREADY,
   output logic [DATA_WIDTH-1:0]          s_RDATA,
   output logic [1:0]                     s_RRESP,
   output logic [NUM_REGS*DATA_WIDTH-1:0] oREGS,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] iSTATUS,
   output logic [NUM_REGS-1:0]            oWR_PULSE,
   output logic [NUM_REGS-1:0]            oRD_PULSE
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;
   localparam int unsigned IdxWidth  = clog2(NUM_REGS);

   w_state_e                               w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0]                  awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]                  wdata_q, wdata_d;
   logic [StrbWidth-1:0]                   wstrb_q, wstrb_d;
   logic                                   bvalid_q, bvalid_d;
   logic [1:0]                             bresp_q, bresp_d;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    regs_q, regs_d;
   logic [NUM_REGS-1:0]                    wr_pulse_q, wr_pulse_d;
   r_state_e                               r_state_q, r_state_d;
   logic                                   rvalid_q, rvalid_d;
   logic [1:0]                             rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]                  rdata_q, rdata_d;
   logic [NUM_REGS-1:0]                    rd_pulse_q, rd_pulse_d;

   logic                  aw_hs, w_hs, ar_hs, enter_resp;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [StrbWidth-1:0]  wr_strb;
   logic [IdxWidth-1:0]   wr_index, rd_index;
   logic                  wr_in_range, wr_is_ro, rd_in_range, rd_is_ro;
   logic                  unused_prot;

   assign unused_prot = ^{s_AWPROT, s_ARPROT};

   // READYs are gated by iRST so they drop the instant reset asserts.
   assign s_AWREADY = iRST && ((w_state_q == WIdle) || (w_state_q == WWaitAddr));
   assign s_WREADY  = iRST && ((w_state_q == WIdle) || (w_state_q == WWaitData));
   assign s_ARREADY = iRST && (r_state_q == RIdle);

   assign aw_hs = s_AWVALID && s_AWREADY;
   assign w_hs  = s_WVALID && s_WREADY;
   assign ar_hs = s_ARVALID && s_ARREADY;

   // Use the live channel when its handshake completes this cycle, else the captured copy.
   assign wr_addr = aw_hs ? s_AWADDR : awaddr_q;
   assign wr_data = w_hs ? s_WDATA : wdata_q;
   assign wr_strb = w_hs ? s_WSTRB : wstrb_q;

   axi4_lite_addr_decode #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_REGS  (NUM_REGS),
      .IDX_WIDTH (IdxWidth),
      .BASE_ADDR (BASE_ADDR),
      .RO_MASK   (RO_MASK)
   ) u_wr_decode (
      .addr_i    (wr_addr),
      .index_o   (wr_index),
      .in_range_o(wr_in_range),
      .is_ro_o   (wr_is_ro)
   );

   axi4_lite_addr_decode #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_REGS  (NUM_REGS),
      .IDX_WIDTH (IdxWidth),
      .BASE_ADDR (BASE_ADDR),
      .RO_MASK   (RO_MASK)
   ) u_rd_decode (
      .addr_i    (s_ARADDR),
      .index_o   (rd_index),
      .in_range_o(rd_in_range),
      .is_ro_o   (rd_is_ro)
   );

   always_comb begin
      w_state_d  = w_state_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      regs_d     = regs_q;
      wr_pulse_d = '0;
      enter_resp = 1'b0;
      if (aw_hs) awaddr_d = s_AWADDR;
      if (w_hs) begin
         wdata_d = s_WDATA;
         wstrb_d = s_WSTRB;
      end
      unique case (w_state_q)
         WIdle: begin
            if (aw_hs && w_hs) enter_resp = 1'b1;
            else if (aw_hs)    w_state_d  = WWaitData;
            else if (w_hs)     w_state_d  = WWaitAddr;
         end
         WWaitData: if (w_hs)  enter_resp = 1'b1;
         WWaitAddr: if (aw_hs) enter_resp = 1'b1;
         WResp: begin
            if (s_BREADY) begin
               w_state_d = WIdle;
               bvalid_d  = 1'b0;
            end
         end
         default: w_state_d = WIdle;
      endcase
      if (enter_resp) begin
         w_state_d = WResp;
         bvalid_d  = 1'b1;
         bresp_d   = !wr_in_range ? RespDecerr : (wr_is_ro ? RespSlverr : RespOkay);
         if (wr_in_range && !wr_is_ro) begin
            wr_pulse_d[wr_index] = 1'b1;
            for (int unsigned k = 0; k < StrbWidth; k++) begin
               if (wr_strb[k]) regs_d[wr_index][8*k +: 8] = wr_data[8*k +: 8];
            end
         end
      end
   end

   // Reads sample regs_q, so a same-cycle write is not yet visible.
   always_comb begin
      r_state_d  = r_state_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      rd_pulse_d = '0;
      unique case (r_state_q)
         RIdle: begin
            if (ar_hs) begin
               r_state_d = RData;
               rvalid_d  = 1'b1;
               if (!rd_in_range) begin
                  rresp_d = RespDecerr;
                  rdata_d = '0;
               end else begin
                  rresp_d              = RespOkay;
                  rdata_d              = rd_is_ro ? iSTATUS[rd_index*DATA_WIDTH +: DATA_WIDTH]
                                                  : regs_q[rd_index];
                  rd_pulse_d[rd_index] = 1'b1;
               end
            end
         end
         RData: begin
            if (s_RREADY) begin
               r_state_d = RIdle;
               rvalid_d  = 1'b0;
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         w_state_q  <= WIdle;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RespOkay;
         regs_q     <= '0;
         wr_pulse_q <= '0;
         r_state_q  <= RIdle;
         rvalid_q   <= 1'b0;
         rresp_q    <= RespOkay;
         rdata_q    <= '0;
         rd_pulse_q <= '0;
      end else begin
         w_state_q  <= w_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         regs_q     <= regs_d;
         wr_pulse_q <= wr_pulse_d;
         r_state_q  <= r_state_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         rd_pulse_q <= rd_pulse_d;
      end
   end

   assign s_BVALID  = bvalid_q;
   assign s_BRESP   = bresp_q;
   assign s_RVALID  = rvalid_q;
   assign s_RRESP   = rresp_q;
   assign s_RDATA   = rdata_q;
   assign oREGS     = regs_q;
   assign oWR_PULSE = wr_pulse_q;
   assign oRD_PULSE = rd_pulse_q;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
module tb_axi4_lite_regfile_slave;

   localparam logic [31:0] Base = 32'h0000_1000;
   localparam logic [15:0] Ro   = 16'h0008;

   logic         clk, rst_n;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  awaddr, araddr, wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [511:0] regs_out, status;
   logic [15:0]  wr_pulse, rd_pulse;

   int n_vec, n_bad;

   logic [31:0] mregs [16];

   typedef struct packed {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [18];

   axi4_lite_regfile_slave #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .NUM_REGS  (16),
      .BASE_ADDR (Base),
      .RO_MASK   (Ro)
   ) dut (
      .iCLK     (clk),
      .iRST     (rst_n),
      .s_AWVALID(awvalid),
      .s_AWREADY(awready),
      .s_AWADDR (awaddr),
      .s_AWPROT (3'b000),
      .s_WVALID (wvalid),
      .s_WREADY (wready),
      .s_WDATA  (wdata),
      .s_WSTRB  (wstrb),
      .s_BVALID (bvalid),
      .s_BREADY (bready),
      .s_BRESP  (bresp),
      .s_ARVALID(arvalid),
      .s_ARREADY(arready),
      .s_ARADDR (araddr),
      .s_ARPROT (3'b000),
      .s_RVALID (rvalid),
      .s_RREADY (rready),
      .s_RDATA  (rdata),
      .s_RRESP  (rresp),
      .oREGS    (regs_out),
      .iSTATUS  (status),
      .oWR_PULSE(wr_pulse),
      .oRD_PULSE(rd_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_index(input logic [31:0] a);
      logic [31:0] word;
      if (a < Base) return -1;
      word = (a - Base) / 4;
      if (word >= 16) return -1;
      return int'(word);
   endfunction

   task automatic m_write(input logic [31:0] a, d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse);
      int idx;
      idx   = m_index(a);
      pulse = '0;
      if (idx < 0) resp = 2'b11;
      else if (Ro[idx]) resp = 2'b10;
      else begin
         resp       = 2'b00;
         pulse[idx] = 1'b1;
         for (int k = 0; k < 4; k++) if (s[k]) mregs[idx][8*k +: 8] = d[8*k +: 8];
      end
   endtask

   task automatic m_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output logic [15:0] pulse);
      int idx;
      idx   = m_index(a);
      pulse = '0;
      if (idx < 0) begin
         resp = 2'b11;
         d    = '0;
      end else begin
         resp       = 2'b00;
         pulse[idx] = 1'b1;
         d          = Ro[idx] ? status[idx*32 +: 32] : mregs[idx];
      end
   endtask

   function automatic logic [511:0] m_flat();
      logic [511:0] f;
      for (int i = 0; i < 16; i++) f[i*32 +: 32] = Ro[i] ? 32'h0 : mregs[i];
      return f;
   endfunction

   // ---------------- bus tasks (start and end #1 after a rising edge) ----------------
   task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pulse);
      int  n;
      bit  hs_aw, hs_w;
      n       = 0;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      while ((awvalid || wvalid) && n < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         @(posedge clk);
         #1;
         if (hs_aw) awvalid = 1'b0;
         if (hs_w) wvalid = 1'b0;
         n++;
      end
      if (awvalid || wvalid) begin
         n_vec++;
         n_bad++;
         $display("FAIL wr_handshake: got timeout required handshake");
         awvalid = 1'b0;
         wvalid  = 1'b0;
      end
      check("bvalid_latency", bvalid, 1'b1);
      resp  = bresp;
      pulse = wr_pulse;
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic [15:0] pulse);
      int n;
      bit hs;
      n       = 0;
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b1;
      while (arvalid && n < 20) begin
         hs = arready;
         @(posedge clk);
         #1;
         if (hs) arvalid = 1'b0;
         n++;
      end
      if (arvalid) begin
         n_vec++;
         n_bad++;
         $display("FAIL rd_handshake: got timeout required handshake");
         arvalid = 1'b0;
      end
      check("rvalid_latency", rvalid, 1'b1);
      d     = rdata;
      resp  = rresp;
      pulse = rd_pulse;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]  resp, mresp;
      logic [31:0] d, md;
      logic [15:0] pulse, mpulse;
      logic [31:0] a;

      n_vec = 0;
      n_bad = 0;
      for (int i = 0; i < 16; i++) begin
         mregs[i]          = '0;
         status[i*32 +: 32] = 32'hBAD0_0000 | i;
      end
      status[3*32 +: 32] = 32'hCAFE_0001;

      //             wr    addr         data          strb  resp   rdata
      tbl[0]  = '{1'b1, Base + 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b0, Base + 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, Base + 32'h06, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, Base + 32'h08, 32'h11223344, 4'hF, 2'b00, 32'h0};
      tbl[4]  = '{1'b0, Base + 32'h0C, 32'h0,        4'h0, 2'b00, 32'hCAFE0001};
      tbl[5]  = '{1'b1, Base + 32'h0C, 32'h12345678, 4'hF, 2'b10, 32'h0};
      tbl[6]  = '{1'b0, Base + 32'h0C, 32'h0,        4'h0, 2'b00, 32'hCAFE0001};
      tbl[7]  = '{1'b0, Base + 32'h40, 32'h0,        4'h0, 2'b11, 32'h0};
      tbl[8]  = '{1'b1, Base + 32'h40, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0};
      tbl[9]  = '{1'b0, Base - 32'h04, 32'h0,        4'h0, 2'b11, 32'h0};
      tbl[10] = '{1'b1, Base + 32'h00, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
      tbl[11] = '{1'b0, Base + 32'h00, 32'h0,        4'h0, 2'b00, 32'h0};
      tbl[12] = '{1'b1, Base + 32'h14, 32'hA5A5A5A5, 4'h5, 2'b00, 32'h0};
      tbl[13] = '{1'b0, Base + 32'h14, 32'h0,        4'h0, 2'b00, 32'h00A500A5};
      tbl[14] = '{1'b1, Base + 32'h18, 32'h66666666, 4'hF, 2'b00, 32'h0};
      tbl[15] = '{1'b1, Base + 32'h3C, 32'h0000BEEF, 4'h3, 2'b00, 32'h0};
      tbl[16] = '{1'b0, Base + 32'h3C, 32'h0,        4'h0, 2'b00, 32'h0000BEEF};
      tbl[17] = '{1'b0, Base + 32'h08, 32'h0,        4'h0, 2'b00, 32'h11223344};

      rst_n   = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      bready  = 1'b1;
      rready  = 1'b1;
      awaddr  = '0;
      araddr  = '0;
      wdata   = '0;
      wstrb   = '0;

      // Reset state
      #12;
      check("rst_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, '0);
      check("rst_rdata", rdata, '0);
      check("rst_regs", regs_out, '0);
      check("rst_pulses", {wr_pulse, rd_pulse}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", {awready, wready, arready}, 3'b111);
      @(posedge clk);
      #1;

      // Table-driven vectors
      for (int i = 0; i < 18; i++) begin
         if (tbl[i].is_wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, resp, pulse);
            m_write(tbl[i].addr, tbl[i].data, tbl[i].strb, mresp, mpulse);
            check($sformatf("tbl%0d_bresp", i), resp, tbl[i].exp_resp);
            check($sformatf("tbl%0d_wpulse", i), pulse, mpulse);
            check($sformatf("tbl%0d_regs", i), regs_out, m_flat());
         end else begin
            do_read(tbl[i].addr, d, resp, pulse);
            m_read(tbl[i].addr, md, mresp, mpulse);
            check($sformatf("tbl%0d_rresp", i), resp, tbl[i].exp_resp);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_rpulse", i), pulse, mpulse);
         end
      end

      // W handshake 3 cycles ahead of AW; byte write over 0x11223344
      wdata  = 32'h0000_00AA;
      wstrb  = 4'h1;
      wvalid = 1'b1;
      @(posedge clk);
      #1;
      wvalid = 1'b0;
      check("wfirst_wait", {awready, wready, bvalid}, 3'b100);
      repeat (2) @(posedge clk);
      #1;
      check("wfirst_still", {awready, wready, bvalid}, 3'b100);
      awaddr  = Base + 32'h08;
      awvalid = 1'b1;
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      m_write(Base + 32'h08, 32'h0000_00AA, 4'h1, mresp, mpulse);
      check("wfirst_bvalid", {bvalid, bresp}, {1'b1, 2'b00});
      check("wfirst_reg2", regs_out[2*32 +: 32], 32'h1122_33AA);
      check("wfirst_pulse", wr_pulse, 16'h0004);
      @(posedge clk);
      #1;
      check("wfirst_pulse_end", {bvalid, wr_pulse}, '0);

      // Back-pressure with concurrent write and read of the same register
      bready  = 1'b0;
      rready  = 1'b0;
      awaddr  = Base + 32'h18;
      wdata   = 32'h0000_0005;
      wstrb   = 4'hF;
      araddr  = Base + 32'h18;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      arvalid = 1'b1;
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      m_read(Base + 32'h18, md, mresp, mpulse);
      m_write(Base + 32'h18, 32'h0000_0005, 4'hF, resp, pulse);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_hold%0d", c),
               {bvalid, rvalid, bresp, rresp, rdata, awready, wready, arready},
               {1'b1, 1'b1, resp, mresp, md, 3'b000});
         @(posedge clk);
         #1;
      end
      bready = 1'b1;
      rready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
      check("bp_regs", regs_out, m_flat());

      // Randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         a = Base - 32'h8 + $urandom_range(0, 32'h50);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            do_write(a, d, wstrb, resp, pulse);
            m_write(a, d, wstrb, mresp, mpulse);
            check($sformatf("rnd%0d_bresp", i), resp, mresp);
            check($sformatf("rnd%0d_wpulse", i), pulse, mpulse);
            check($sformatf("rnd%0d_regs", i), regs_out, m_flat());
         end else begin
            do_read(a, d, resp, pulse);
            m_read(a, md, mresp, mpulse);
            check($sformatf("rnd%0d_rresp", i), resp, mresp);
            check($sformatf("rnd%0d_rdata", i), d, md);
            check($sformatf("rnd%0d_rpulse", i), pulse, mpulse);
         end
      end

      // Reset while waiting for write data
      awaddr  = Base + 32'h1C;
      awvalid = 1'b1;
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      check("rstmid_wait_data", {awready, wready}, 2'b01);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_ctrl", {awready, wready, arready, bvalid, rvalid}, '0);
      check("rstmid_regs", regs_out, '0);
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rstmid_ready", {awready, wready, arready, bvalid}, 4'b1110);
      do_write(Base + 32'h1C, 32'h7777_0077, 4'hF, resp, pulse);
      m_write(Base + 32'h1C, 32'h7777_0077, 4'hF, mresp, mpulse);
      check("rstmid_bresp", resp, 2'b00);
      check("rstmid_regs_after", regs_out, m_flat());
      do_read(Base + 32'h1C, d, resp, pulse);
      check("rstmid_rdata", {resp, d}, {2'b00, 32'h7777_0077});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/axi4_lite_regfile_slave.md
# axi4_lite_regfile_slave

Parametrised AXI4-Lite slave with a built-in register file of NUM_REGS words. It supports byte-strobed writes, read-only status registers, and independent read and write channels. Out-of-range and illegal accesses return real AXI error responses. It is the next-generation replacement for the fixed single-interface slave wrapper, and sits directly on an interconnect master port.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: data width; must be 32 or 64.
- NUM_REGS, 16: register count; must be ≥2.
- BASE_ADDR, 0: byte base address; must be aligned to NUM_REGS*DATA_WIDTH/8.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only (reads return iSTATUS slice i).
- iCLK  in  1  single clock, all logic rising-edge.
- iRST  in  1  asynchronous, active-low reset.
- s_AWVALID/s_AWREADY/s_AWADDR/s_AWPROT  AXI write address channel (in/out/ADDR_WIDTH/3). AWPROT is ignored.
- s_WVALID/s_WREADY/s_WDATA/s_WSTRB  AXI write data channel (in/out/DATA_WIDTH/DATA_WIDTH/8).
- s_BVALID/s_BREADY/s_BRESP  AXI write response channel (out/in/2).
- s_ARVALID/s_ARREADY/s_ARADDR/s_ARPROT  AXI read address channel (in/out/ADDR_WIDTH/3). ARPROT is ignored.
- s_RVALID/s_RREADY/s_RDATA/s_RRESP  AXI read data channel (out/in/DATA_WIDTH/2).
- oREGS  out  NUM_REGS*DATA_WIDTH  flat view of all read/write registers; slice i is register i.
- iSTATUS  in  NUM_REGS*DATA_WIDTH  status sources; only slices with RO_MASK bit set are used.
- oWR_PULSE  out  NUM_REGS  one-cycle pulse on the cycle a register's new value becomes visible.
- oRD_PULSE  out  NUM_REGS  one-cycle pulse on the cycle s_RVALID rises for a register.

## Operation
- Decode:
  - offset = addr − BASE_ADDR; index = offset >> log2(DATA_WIDTH/8); low address bits are ignored.
  - addr < BASE_ADDR or index ≥ NUM_REGS → DECERR (2'b11).
  - Write to a read-only register → SLVERR (2'b10), no state change.
  - Otherwise → OKAY (2'b00). EXOKAY is never returned.
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
  - AW only → W_WAIT_DATA (AWREADY=0). W only → W_WAIT_ADDR (WREADY=0). Both → W_RESP.
  - W_WAIT_DATA/W_WAIT_ADDR: the remaining handshake → W_RESP.
  - W_RESP: AWREADY=WREADY=0, BVALID=1 until BREADY, then → W_IDLE.
- Write commit, on the edge entering W_RESP when the response is OKAY:
  - byte k of register index ← WDATA byte k where WSTRB[k]=1; other bytes are unchanged.
  - WSTRB=0 gives OKAY with no change, and oWR_PULSE still fires.
- Read FSM states:
  - R_IDLE: ARREADY=1; handshake → R_DATA.
  - R_DATA: ARREADY=0, RVALID=1, RDATA/RRESP held stable until RREADY, then → R_IDLE.
  - RDATA comes from the register for R/W registers and from iSTATUS for RO registers, sampled on the AR handshake edge. On DECERR, RDATA=0.
- The read and write channels are fully independent. A same-cycle read and write of the same register returns the pre-write value.

## Timing
- Reset values: all registers 0; s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID = 0; s_BRESP, s_RRESP, s_RDATA = 0; pulses 0.
- First cycle after reset deasserts: both FSMs in IDLE, with all three READYs high.
- Write latency: last of the AW/W handshakes at edge N → oREGS updated, oWR_PULSE and BVALID high from edge N+1.
- Read latency: AR handshake at edge N → RVALID from edge N+1.
- Throughput: one write per 2 cycles and one read per 2 cycles, with BREADY/RREADY held high.
- VALID is never dependent on READY. Outputs hold while VALID=1 and READY=0.
- Reset mid-transaction: asynchronous, immediate. Any pending response is dropped and no partial write is committed.

## Structure
- Package axi4_lite_pkg:
  - response codes OKAY, EXOKAY, SLVERR, DECERR;
  - write and read FSM state encodings;
  - a function clog2 for byte-lane shift.
- Sub-module axi4_lite_addr_decode, instantiated twice (write and read). It is combinational: addr → index, in_range, is_ro.

## Test plan
- Reset, then write 0xDEADBEEF to BASE+0x4 with WSTRB=0xF → BRESP=OKAY, oREGS slice 1=0xDEADBEEF, oWR_PULSE[1] one cycle; read returns 0xDEADBEEF, RRESP=OKAY.
- W issued 3 cycles before AW: 0x000000AA to BASE+0x8 with WSTRB=0x1 over an existing 0x11223344 → register 2=0x112233AA, BVALID one cycle after the AW handshake.
- RO_MASK=0x8, iSTATUS slice 3=0xCAFE0001 → read BASE+0xC returns 0xCAFE0001/OKAY; write there returns SLVERR and the value is unchanged.
- Read and write BASE+NUM_REGS*4 → RRESP=DECERR with RDATA=0, BRESP=DECERR, no oREGS change.
- Hold BREADY/RREADY low for 5 cycles with a concurrent write and read → BVALID, RVALID, responses and data stay stable; AWREADY/ARREADY stay 0 until the respective handshake.
- Assert iRST during W_WAIT_DATA → immediately all READY/VALID=0, registers=0, and the next full write completes normally.
